// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : controller state encoding (IDLE / RUN / DONE)
//   div_cnt_w() : width of the iteration counter for a given operand width
package div_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    // Counter only needs to reach WIDTH-1.
    function automatic int unsigned div_cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_seq_ctrl_sub_step.sv
// div_sub_step: combinational (WIDTH+1)-bit trial subtraction diff = s - d,
// built as s + ~d + 1 on a ripple full-adder chain.
//   s      : partial remainder after shift (WIDTH+1 bits)
//   d      : zero-extended divisor (WIDTH+1 bits)
//   diff   : s - d modulo 2^(WIDTH+1)
//   borrow : top bit of diff; set when s < d
module div_sub_step
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0] s,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH:0] d_inv;
    logic [WIDTH:0] carry;

    assign d_inv = ~d;

    // Carry-in of 1 completes the two's-complement negation of d.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            diff[i] = s[i] ^ d_inv[i] ^ carry[i];
            if (i < WIDTH) begin
                carry[i+1] = (s[i] & d_inv[i]) | (s[i] & carry[i]) | (d_inv[i] & carry[i]);
            end
        end
    end

    // Partial remainder is always < 2*d, so the top difference bit is the borrow.
    assign borrow = diff[WIDTH];

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequential restoring divider for unsigned WIDTH-bit operands.
// One trial subtraction per RUN cycle; WIDTH cycles per operation.
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : request, accepted in IDLE or DONE
//   dividend, divisor    : operands, captured on the accepted start edge
//   busy                 : high while iterating
//   done                 : one-cycle pulse, results valid from this cycle
//   quotient, remainder  : results, held until the next accepted start
//   div_by_zero          : captured divisor was zero; held with results
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = div_cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   step_d;
    logic [WIDTH:0]   step_diff;
    logic             step_borrow;
    logic             step_unused;

    assign step_s = {r_q, q_q[WIDTH-1]};
    assign step_d = {1'b0, d_q};

    div_sub_step #(
        .WIDTH(WIDTH)
    ) u_sub_step (
        .s      (step_s),
        .d      (step_d),
        .diff   (step_diff),
        .borrow (step_borrow)
    );

    // Top diff bit duplicates borrow; only the low WIDTH bits are stored.
    assign step_unused = step_diff[WIDTH];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            DIV_IDLE, DIV_DONE: begin
                state_d = DIV_IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_d = DIV_RUN;
                        d_d     = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        count_d = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = DIV_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end

            DIV_RUN: begin
                if (!step_borrow) begin
                    r_d = step_diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = step_s[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_DONE;
                    count_d = '0;
                    quot_d  = q_d;
                    rem_d   = r_d;
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == DIV_RUN);
    assign done        = (state_q == DIV_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
